// File: rtl/i2s_if_gen.sv
// I2S / left-justified serial audio master: LRCK generation, stereo TX serialiser
// and RX deserialiser with a valid/ack holding register.
module i2s_if_gen #(
  parameter int SAMPLE_W = 16,
  parameter int DIV_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  LRCK,
  output logic                  SDOUT,
  input  logic                  SDIN,
  output logic                  AUD_nRESET,
  input  logic                  tx_enable,
  input  logic                  rx_enable,
  input  logic                  mode_lj,
  input  logic                  mono,
  input  logic [DIV_W-1:0]      div_ratio,
  input  logic                  audio_reset,
  input  logic [2*SAMPLE_W-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ack,
  output logic [2*SAMPLE_W-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ack,
  output logic                  tx_underrun,
  output logic                  rx_overrun
);

  localparam int CW = $clog2(SAMPLE_W + 1) + 1;
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(SAMPLE_W + 1);

  typedef enum logic [2:0] {
    IDLE, LSTART, LDATA, LWAIT, RSTART, RDATA, RWAIT
  } state_t;

  state_t                state, state_nxt;
  logic [DIV_W-1:0]      cnt;
  logic [DIV_W-1:0]      eff_div;
  logic                  reload;
  logic                  any_en;
  logic                  tx_go;
  logic [CW-1:0]         slot_cnt;
  logic [CW-1:0]         bit_idx;
  logic                  lj_eff;
  logic                  bit_act;
  logic                  last_bit;
  logic                  mode_r;
  logic                  rx_on;
  logic                  copy_pend;
  logic                  lrck_r;
  logic [SAMPLE_W-1:0]   tx_l, tx_r;
  logic [SAMPLE_W-1:0]   cur_word, shifted;
  logic [2*SAMPLE_W-1:0] rx_shift;

  assign any_en  = tx_enable | rx_enable;
  assign tx_go   = tx_enable & data_in_valid;
  assign eff_div = (div_ratio < MIN_DIV) ? MIN_DIV : div_ratio;
  assign reload  = (cnt == DIV_W'(1));

  // The START cycle of a slot uses the live mode; later cycles use the copy taken in LSTART.
  assign lj_eff   = (state == LSTART) ? mode_lj : mode_r;
  assign bit_act  = (state == LDATA) || (state == RDATA) ||
                    (((state == LSTART) || (state == RSTART)) && lj_eff);
  assign bit_idx  = lj_eff ? slot_cnt : (slot_cnt - CW'(1));
  assign last_bit = (bit_idx == CW'(SAMPLE_W - 1));

  assign data_in_ack = (state == LSTART) && tx_go;
  assign tx_underrun = (state == LSTART) && tx_enable && !data_in_valid;
  assign LRCK        = lrck_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= DIV_W'(1);
    end else if ((state == IDLE) && !any_en) begin
      cnt <= DIV_W'(1);
    end else if (reload) begin
      cnt <= eff_div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // With the minimum divider the last I2S bit lands on the reload cycle, so the
  // DATA states may have to skip WAIT and start the next slot directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (reload && any_en) state_nxt = LSTART;
      LSTART: state_nxt = LDATA;
      LDATA:  if (last_bit) state_nxt = reload ? RSTART : LWAIT;
      LWAIT:  if (reload) state_nxt = RSTART;
      RSTART: state_nxt = RDATA;
      RDATA: begin
        if (last_bit) begin
          if (reload) state_nxt = any_en ? LSTART : IDLE;
          else        state_nxt = RWAIT;
        end
      end
      RWAIT:  if (reload) state_nxt = any_en ? LSTART : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      lrck_r   <= 1'b1;
    end else begin
      if ((state_nxt == LSTART) || (state_nxt == RSTART)) begin
        slot_cnt <= '0;
      end else if ((state == LSTART) || (state == LDATA) ||
                   (state == RSTART) || (state == RDATA)) begin
        slot_cnt <= slot_cnt + CW'(1);
      end
      lrck_r <= !((state_nxt == LSTART) || (state_nxt == LDATA) || (state_nxt == LWAIT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
      rx_on  <= 1'b0;
      tx_l   <= '0;
      tx_r   <= '0;
    end else if (state == LSTART) begin
      mode_r <= mode_lj;
      rx_on  <= rx_enable;
      tx_l   <= tx_go ? data_in[2*SAMPLE_W-1:SAMPLE_W] : '0;
      tx_r   <= tx_go ? (mono ? data_in[2*SAMPLE_W-1:SAMPLE_W] : data_in[SAMPLE_W-1:0]) : '0;
    end
  end

  always_comb begin
    cur_word = '0;
    case (state)
      LSTART:        cur_word = tx_go ? data_in[2*SAMPLE_W-1:SAMPLE_W] : '0;
      LDATA:         cur_word = tx_l;
      RSTART, RDATA: cur_word = tx_r;
      default:       cur_word = '0;
    endcase
    shifted = cur_word << bit_idx;
    SDOUT   = bit_act & shifted[SAMPLE_W-1];
  end

  // The copy runs one cycle after the last right bit so rx_shift already holds the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift       <= '0;
      copy_pend      <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      rx_overrun     <= 1'b0;
    end else begin
      if (bit_act) rx_shift <= {rx_shift[2*SAMPLE_W-2:0], SDIN};
      copy_pend  <= (state == RDATA) && last_bit && rx_on;
      rx_overrun <= 1'b0;
      if (copy_pend) begin
        data_out       <= rx_shift;
        data_out_valid <= 1'b1;
        rx_overrun     <= data_out_valid && !data_out_ack;
      end else if (data_out_ack) begin
        data_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AUD_nRESET <= 1'b0;
    end else begin
      AUD_nRESET <= !audio_reset;
    end
  end

endmodule

// File: doc/i2s_if_gen.md
Name: i2s_if_gen

Overview:
- Parametrised I2S/left-justified serial audio master for the APB audio subsystem; successor to the fixed 16-bit I2S interface.
- Generates LRCK from the interface clock and serialises stereo TX words onto SDOUT.
- Deserialises SDIN into a holding register with a valid/ack handshake.
- Adds generic sample width, left-justified mode, mono duplication, divider clamping and a non-dropping RX holding register.

Parameters:
SAMPLE_W, 16, bits per channel sample (8..32)
DIV_W, 10, width of the LRCK half-period divider

Ports:
clk  in  1  interface bit clock
rst_n  in  1  asynchronous active-low reset
LRCK  out  1  left/right clock; 0 = left slot, 1 = right slot
SDOUT  out  1  serial data out, MSB first
SDIN  in  1  serial data in, MSB first
AUD_nRESET  out  1  codec reset, active low
tx_enable  in  1  enable transmit
rx_enable  in  1  enable receive
mode_lj  in  1  0 = I2S (1-cycle delay), 1 = left-justified (no delay)
mono  in  1  1 = transmit left sample in both slots
div_ratio  in  DIV_W  LRCK half-period in clk cycles
audio_reset  in  1  request codec reset
data_in  in  2*SAMPLE_W  TX word; [2W-1:W] = left, [W-1:0] = right
data_in_valid  in  1  TX word available
data_in_ack  out  1  TX word consumed (1-cycle pulse)
data_out  out  2*SAMPLE_W  RX word, same packing as data_in
data_out_valid  out  1  RX word held
data_out_ack  in  1  RX word consumed
tx_underrun  out  1  1-cycle pulse: frame started with no TX data
rx_overrun  out  1  1-cycle pulse: unacknowledged RX word overwritten

Behaviour:
- Reset values: LRCK=1, SDOUT=0, AUD_nRESET=0, data_out=0, data_out_valid=0, data_in_ack=0, tx_underrun=0, rx_overrun=0. FSM=IDLE, divider counter=1.
- Reset is asynchronous; assertion mid-frame aborts immediately.
- Effective divider: eff_div = max(div_ratio, SAMPLE_W+1), so div_ratio=0 is also clamped.
- Divider counter:
  - Reload condition = counter==1.
  - In IDLE with tx_enable=rx_enable=0, the counter is held at 1.
  - Otherwise it decrements and, on reload, loads eff_div sampled in that cycle. Each LRCK half therefore lasts eff_div cycles.
- FSM states: IDLE, LSTART, LDATA, LWAIT, RSTART, RDATA, RWAIT.
  - IDLE->LSTART on reload & (tx_enable|rx_enable).
  - LSTART->LDATA; LDATA->LWAIT after the last bit.
  - LWAIT->RSTART on reload.
  - RSTART->RDATA; RDATA->RWAIT after the last bit.
  - RWAIT on reload -> LSTART if (tx_enable|rx_enable), else IDLE.
  - Unused encodings -> IDLE.
- LRCK toggles on a reload edge only when the next state is LSTART or RSTART. It parks at 1 in IDLE. Disabling mid-frame completes the current frame.
- Enable latency: enable asserted in cycle t while IDLE -> LRCK=0 and state LSTART in cycle t+1.
- Slot cycle numbering: cycle 0 = first cycle LRCK shows the new value (the START state).
  - I2S mode: data bit k (k=0 is the MSB) occupies slot cycle k+1.
  - LJ mode: data bit k occupies slot cycle k.
  - SDOUT=0 in all other cycles.
- TX path:
  - In LSTART, if tx_enable & data_in_valid: latch data_in and pulse data_in_ack.
  - If tx_enable & ~data_in_valid: pulse tx_underrun and transmit zeros for the whole frame.
  - If tx_enable=0: SDOUT stays 0.
  - With mono=1, the left sample is sent in the right slot as well; mono is sampled in LSTART.
- RX path:
  - SDIN is sampled on the same slot cycles that carry data bits, MSB first, into a receive shift register.
  - One cycle after the last right bit is sampled, if rx_enable (sampled in LSTART) was set: the word is copied to data_out and data_out_valid is set.
  - If data_out_valid=1 and data_out_ack=0 in the copy cycle: the copy still occurs, valid stays 1, and rx_overrun pulses.
  - data_out_ack while valid=1 clears valid next cycle. If the ack coincides with a copy, valid stays 1 with the new word and there is no overrun.
  - data_out is stable while valid=1 except on overwrite.
- AUD_nRESET = ~audio_reset registered one cycle.

Test Plan:
- SAMPLE_W=16, div_ratio=20, I2S, data_in=0xA5A53C3C valid, tx_enable rises at t -> LRCK=0 at t+1. data_in_ack pulse at t+1. SDOUT=0 at t+1, then 1010010110100101 in cycles t+2..t+17. LRCK=1 at t+21, right bits 0011110000111100 in cycles t+22..t+37.
- Same settings, mode_lj=1, mono=1 -> left MSB at t+1. Right slot carries 0xA5A5 starting at t+21.
- rx_enable only, SDIN loopback of the first scenario's SDOUT pattern -> data_out=0xA5A53C3C, data_out_valid=1 one cycle after the last right bit. Hold data_out_ack=0 for the next frame (SDIN pattern 0x12345678) -> rx_overrun pulse, data_out=0x12345678.
- tx_enable with data_in_valid=0 -> tx_underrun pulse in LSTART, SDOUT=0 for the frame, no data_in_ack.
- div_ratio=5 -> LRCK half-period 17 cycles. Deassert enables mid-left-slot -> frame completes, LRCK parks at 1, FSM in IDLE.
- Assert rst_n=0 mid-RDATA -> all outputs return to reset values immediately. audio_reset=1 -> AUD_nRESET=0 one cycle later.
